// File: rtl/batting_roulette.sv
// batting_roulette: ring of NSLOTS outcome slots that spins while `active`
// is high, decelerates for DECEL_STEPS steps after `swing`, then latches the
// landed outcome and pulses result_valid for one cycle.
// Optional feature macro: BATTING_STATS_EN adds saturating swing/hit counters.
module batting_roulette #(
  parameter int              NSLOTS      = 13,
  parameter logic [3*NSLOTS-1:0] SLOT_MAP = {3'd0, 3'd0, 3'd4, 3'd2, 3'd3, 3'd0, 3'd0,
                                             3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0},
  parameter int              RESET_SLOT  = 12,
  parameter int              PRESCALE    = 1,
  parameter int              DECEL_STEPS = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       active,
  input  logic       swing,
  output logic [4:0] hitout,
  output logic       busy,
  output logic [4:0] result,
  output logic       result_valid
`ifdef BATTING_STATS_EN
  ,
  output logic [7:0] swing_cnt,
  output logic [7:0] hit_cnt
`endif
);

  localparam int PW = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;
  localparam int NTAB = 2 ** PW;

  localparam logic [PW-1:0] SLOT_LAST  = PW'(NSLOTS - 1);
  localparam logic [PW-1:0] SLOT_RESET = PW'(RESET_SLOT);
  localparam logic [7:0]    TICK_INIT  = 8'(PRESCALE - 1);
  localparam logic [15:0]   WAIT_INIT  = 16'(2 * PRESCALE - 1);
  localparam logic [15:0]   PRESCALE_W = 16'(PRESCALE);
  localparam logic [3:0]    DECEL_INIT = 4'(DECEL_STEPS);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DECEL = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // 3-bit outcome code to {hit1,hit2,hit3,hit4,out}; unused codes give zero
  function automatic logic [4:0] decode(input logic [2:0] code);
    case (code)
      3'd0:    decode = 5'b00001;
      3'd1:    decode = 5'b10000;
      3'd2:    decode = 5'b01000;
      3'd3:    decode = 5'b00100;
      3'd4:    decode = 5'b00010;
      default: decode = 5'b00000;
    endcase
  endfunction

  // Per-slot one-hot class table, padded to a power of two so any pointer
  // value indexes a defined entry.
  logic [4:0] slot_class [NTAB];

  genvar gi;
  generate
    for (gi = 0; gi < NTAB; gi++) begin : g_class
      if (gi < NSLOTS) begin : g_used
        assign slot_class[gi] = decode(SLOT_MAP[3*gi +: 3]);
      end else begin : g_pad
        assign slot_class[gi] = 5'b00000;
      end
    end
  endgenerate

  state_t        state, state_next;
  logic [PW-1:0] slot, slot_next, slot_inc;
  logic [7:0]    tick, tick_next;
  logic [15:0]   wait_cnt, wait_next, wait_reload;
  logic [3:0]    rem, rem_next;
  logic [3:0]    j_cnt, j_next;
  logic [4:0]    result_next;
  logic          valid_next;

  assign slot_inc    = (slot == SLOT_LAST) ? '0 : slot + PW'(1);
  // Step j+1 lasts PRESCALE*(j+3) cycles; counter holds that minus one
  assign wait_reload = PRESCALE_W * ({12'd0, j_cnt} + 16'd3) - 16'd1;
  assign hitout      = slot_class[slot];
  assign busy        = (state != S_RUN);

  // State, pointer and counter registers; async reset aborts any stop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_RUN;
      slot         <= SLOT_RESET;
      tick         <= TICK_INIT;
      wait_cnt     <= '0;
      rem          <= '0;
      j_cnt        <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      state        <= state_next;
      slot         <= slot_next;
      tick         <= tick_next;
      wait_cnt     <= wait_next;
      rem          <= rem_next;
      j_cnt        <= j_next;
      result       <= result_next;
      result_valid <= valid_next;
    end
  end

  // Next-state logic: spin in RUN, slowing steps in DECEL, latch in DONE
  always_comb begin
    state_next  = state;
    slot_next   = slot;
    tick_next   = tick;
    wait_next   = wait_cnt;
    rem_next    = rem;
    j_next      = j_cnt;
    result_next = result;
    valid_next  = 1'b0;
    case (state)
      S_RUN: begin
        // swing wins over both a pending step and a frozen spin
        if (swing) begin
          if (DECEL_STEPS == 0) begin
            state_next = S_DONE;
          end else begin
            state_next = S_DECEL;
            rem_next   = DECEL_INIT;
            j_next     = '0;
            wait_next  = WAIT_INIT;
          end
        end else if (active) begin
          if (tick == 8'd0) begin
            slot_next = slot_inc;
            tick_next = TICK_INIT;
          end else begin
            tick_next = tick - 8'd1;
          end
        end
      end
      S_DECEL: begin
        if (wait_cnt == 16'd0) begin
          slot_next = slot_inc;
          rem_next  = rem - 4'd1;
          j_next    = j_cnt + 4'd1;
          wait_next = wait_reload;
          if (rem == 4'd1) begin
            state_next = S_DONE;
          end
        end else begin
          wait_next = wait_cnt - 16'd1;
        end
      end
      S_DONE: begin
        result_next = slot_class[slot];
        valid_next  = 1'b1;
        state_next  = S_RUN;
        tick_next   = TICK_INIT;
      end
      default: begin
        state_next = S_RUN;
      end
    endcase
  end

`ifdef BATTING_STATS_EN
  // Saturating statistics, updated on the same edge that latches result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      swing_cnt <= '0;
      hit_cnt   <= '0;
    end else if (state == S_DONE) begin
      if (swing_cnt != 8'hFF) begin
        swing_cnt <= swing_cnt + 8'd1;
      end
      if ((|slot_class[slot][4:1]) && (hit_cnt != 8'hFF)) begin
        hit_cnt <= hit_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_batting_roulette.sv
// tb_batting_roulette: directed stimulus for two roulette instances (default
// parameters, and a 5-slot PRESCALE=4 no-decel variant); results are checked
// by scoreboard monitors that pop expected outcomes and arrival cycles.
module tb_batting_roulette;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, act_a, sw_a, busy_a, rv_a;
  logic [4:0] hit_a, res_a;
  logic       rst_b, act_b, sw_b, busy_b, rv_b;
  logic [4:0] hit_b, res_b;
`ifdef BATTING_STATS_EN
  logic [7:0] sc_a, hc_a, sc_b, hc_b;
`endif

  batting_roulette dut_a (
    .clk          (clk),
    .reset_n      (rst_a),
    .active       (act_a),
    .swing        (sw_a),
    .hitout       (hit_a),
    .busy         (busy_a),
    .result       (res_a),
    .result_valid (rv_a)
`ifdef BATTING_STATS_EN
    ,
    .swing_cnt    (sc_a),
    .hit_cnt      (hc_a)
`endif
  );

  batting_roulette #(
    .NSLOTS      (5),
    .SLOT_MAP    ({3'd4, 3'd2, 3'd3, 3'd0, 3'd1}),
    .RESET_SLOT  (0),
    .PRESCALE    (4),
    .DECEL_STEPS (0)
  ) dut_b (
    .clk          (clk),
    .reset_n      (rst_b),
    .active       (act_b),
    .swing        (sw_b),
    .hitout       (hit_b),
    .busy         (busy_b),
    .result       (res_b),
    .result_valid (rv_b)
`ifdef BATTING_STATS_EN
    ,
    .swing_cnt    (sc_b),
    .hit_cnt      (hc_b)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;

  always @(posedge clk) cyc_cnt++;

  typedef struct {
    logic [4:0] res;
    int         at;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  // Hand-written one-hot class per slot for each instance
  logic [4:0] hot_a [13] = '{5'b00001, 5'b00001, 5'b10000, 5'b00001, 5'b00001,
                             5'b00001, 5'b00001, 5'b00001, 5'b00100, 5'b01000,
                             5'b00010, 5'b00001, 5'b00001};
  logic [4:0] hot_b [5]  = '{5'b10000, 5'b00001, 5'b00100, 5'b01000, 5'b00010};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor for instance A
  always @(negedge clk) begin
    exp_t e;
    if (rv_a === 1'b1) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rv_a_unexpected: result_valid=1 result=%b at cycle %0d, expected no pulse", res_a, cyc_cnt);
      end else begin
        e = qa.pop_front();
        $display("A result %b at cycle %0d", res_a, cyc_cnt);
        chk("res_a", 32'(res_a), 32'(e.res));
        chk("lat_a", cyc_cnt, e.at);
      end
    end
  end

  // Scoreboard monitor for instance B
  always @(negedge clk) begin
    exp_t e;
    if (rv_b === 1'b1) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rv_b_unexpected: result_valid=1 result=%b at cycle %0d, expected no pulse", res_b, cyc_cnt);
      end else begin
        e = qb.pop_front();
        $display("B result %b at cycle %0d", res_b, cyc_cnt);
        chk("res_b", 32'(res_b), 32'(e.res));
        chk("lat_b", cyc_cnt, e.at);
      end
    end
  end

  // Swing at slot s on instance A and follow the three-step deceleration
  task automatic run_decel(input int s, input logic act_val, input logic hold);
    int adv;
    act_a = act_val;
    sw_a  = 1'b1;
    tick_clk();
    qa.push_back(exp_t'{hot_a[(s + 3) % 13], cyc_cnt + 10});
    chk("decel_busy0", 32'(busy_a), 32'd1);
    chk("decel_hold0", 32'(hit_a), 32'(hot_a[s]));
    sw_a = hold;
    for (int k = 1; k <= 10; k++) begin
      tick_clk();
      adv = ((k >= 2) ? 1 : 0) + ((k >= 5) ? 1 : 0) + ((k >= 9) ? 1 : 0);
      chk("decel_hitout", 32'(hit_a), 32'(hot_a[(s + adv) % 13]));
      chk("decel_busy", 32'(busy_a), (k <= 9) ? 32'd1 : 32'd0);
    end
    sw_a  = 1'b0;
    act_a = 1'b0;
  endtask

  initial begin
    logic t2_act [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int   t2_slot [4] = '{0, 0, 0, 1};

    rst_a = 1'b0; act_a = 1'b0; sw_a = 1'b0;
    rst_b = 1'b0; act_b = 1'b0; sw_b = 1'b0;
    #2;
    chk("rst_hitout_a", 32'(hit_a), 32'(hot_a[12]));
    chk("rst_busy_a",   32'(busy_a), 32'd0);
    chk("rst_result_a", 32'(res_a), 32'd0);
    chk("rst_valid_a",  32'(rv_a), 32'd0);
    chk("rst_hitout_b", 32'(hit_b), 32'(hot_b[0]));
    tick_clk();
    tick_clk();
    rst_a = 1'b1;
    rst_b = 1'b1;

    // T1: full revolution from the reset slot
    chk("t1_start", 32'(hit_a), 32'(hot_a[12]));
    act_a = 1'b1;
    for (int i = 0; i < 13; i++) begin
      tick_clk();
      chk("t1_hitout", 32'(hit_a), 32'(hot_a[i]));
    end
    act_a = 1'b0;

    // T2: active gating from a fresh reset
    rst_a = 1'b0;
    tick_clk();
    rst_a = 1'b1;
    chk("t2_start", 32'(hit_a), 32'(hot_a[12]));
    for (int i = 0; i < 4; i++) begin
      act_a = t2_act[i];
      tick_clk();
      chk("t2_hitout", 32'(hit_a), 32'(hot_a[t2_slot[i]]));
      chk("t2_busy", 32'(busy_a), 32'd0);
    end
    act_a = 1'b0;

    // T3: spin from slot 1 to slot 7, swing with active still high
    act_a = 1'b1;
    repeat (6) tick_clk();
    chk("t3_at7", 32'(hit_a), 32'(hot_a[7]));
    run_decel(7, 1'b1, 1'b0);

    // T4: swing held high with active low throughout, starting at slot 10
    run_decel(10, 1'b0, 1'b1);
    repeat (5) tick_clk();
    chk("t4_idle_busy", 32'(busy_a), 32'd0);

    // T6: reset three cycles into a deceleration from slot 8
    act_a = 1'b1;
    repeat (8) tick_clk();
    chk("t6_at8", 32'(hit_a), 32'(hot_a[8]));
    act_a = 1'b0;
    sw_a  = 1'b1;
    tick_clk();
    sw_a = 1'b0;
    repeat (3) tick_clk();
    chk("t6_mid_hitout", 32'(hit_a), 32'(hot_a[9]));
    chk("t6_mid_busy", 32'(busy_a), 32'd1);
    rst_a = 1'b0;
    #1;
    chk("t6_rst_hitout", 32'(hit_a), 32'(hot_a[12]));
    chk("t6_rst_busy", 32'(busy_a), 32'd0);
    chk("t6_rst_result", 32'(res_a), 32'd0);
    repeat (3) tick_clk();
    rst_a = 1'b1;
    repeat (12) tick_clk();
    chk("t6_after_busy", 32'(busy_a), 32'd0);

    // T5: PRESCALE=4 stepping with wrap on the 5-slot instance
    act_b = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      tick_clk();
      chk("t5_hitout", 32'(hit_b), 32'(hot_b[(n / 4) % 5]));
    end
    repeat (8) tick_clk();
    chk("t5_at2", 32'(hit_b), 32'(hot_b[2]));
    act_b = 1'b0;
    sw_b  = 1'b1;
    tick_clk();
    qb.push_back(exp_t'{hot_b[2], cyc_cnt + 1});
    chk("t5_busy", 32'(busy_b), 32'd1);
    chk("t5_hold", 32'(hit_b), 32'(hot_b[2]));
    sw_b = 1'b0;
    tick_clk();
    chk("t5_busy_done", 32'(busy_b), 32'd0);
    act_b = 1'b1;
    repeat (3) tick_clk();
    chk("t5_reload", 32'(hit_b), 32'(hot_b[2]));
    tick_clk();
    chk("t5_step", 32'(hit_b), 32'(hot_b[3]));
    act_b = 1'b0;

`ifdef BATTING_STATS_EN
    // Saturation of both counters after 300 HIT2 landings
    for (int i = 0; i < 300; i++) begin
      sw_b = 1'b1;
      tick_clk();
      qb.push_back(exp_t'{hot_b[3], cyc_cnt + 1});
      sw_b = 1'b0;
      tick_clk();
    end
    repeat (2) tick_clk();
    chk("stats_swing_b", 32'(sc_b), 32'd255);
    chk("stats_hit_b", 32'(hc_b), 32'd255);
    chk("stats_swing_a_cleared", 32'(sc_a), 32'd0);
    chk("stats_hit_a_cleared", 32'(hc_a), 32'd0);
`endif

    repeat (3) tick_clk();
    chk("qa_drained", qa.size(), 32'd0);
    chk("qb_drained", qb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
